// File: rtl/pc_unit.sv
// Fetch program counter with PC+4 and a direct-mapped branch target buffer.
// Lookup is combinational on the current PC; BTB updates land on the next edge.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               BTB_DEPTH    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_target,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] inc_PC,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target
);

    localparam int IDX  = $clog2(BTB_DEPTH);
    localparam int TAGW = WIDTH - IDX - 2;
    localparam int TGTW = WIDTH - 2;

    logic [WIDTH-1:0]     r_pc;
    logic [BTB_DEPTH-1:0] r_valid;
    logic [TAGW-1:0]      r_tag    [BTB_DEPTH];
    logic [TGTW-1:0]      r_target [BTB_DEPTH];

    logic [IDX-1:0]   w_idx;
    logic [TAGW-1:0]  w_tag;
    logic             w_hit;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_pred_target;
    logic [WIDTH-1:0] w_pc_next;
    logic [IDX-1:0]   w_upd_idx;
    logic [TAGW-1:0]  w_upd_tag;
    logic             w_upd_match;
    logic             w_unused;

    assign w_idx         = r_pc[IDX+1:2];
    assign w_tag         = r_pc[WIDTH-1:IDX+2];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_inc         = r_pc + WIDTH'(4);
    assign w_pred_target = w_hit ? {r_target[w_idx], 2'b00} : w_inc;

    assign w_upd_idx   = upd_pc[IDX+1:2];
    assign w_upd_tag   = upd_pc[WIDTH-1:IDX+2];
    assign w_upd_match = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    // Byte-offset bits of incoming addresses are architecturally ignored.
    assign w_unused = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    always_comb begin
        w_pc_next = w_inc;
        if (redirect) begin
            w_pc_next = {redirect_pc[WIDTH-1:2], 2'b00};
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (w_hit) begin
            w_pc_next = w_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // A taken update overwrites whatever aliases at that index; a not-taken
    // update only invalidates an entry that really belongs to upd_pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= upd_target[WIDTH-1:2];
            end else if (w_upd_match) begin
                r_valid[w_upd_idx] <= 1'b0;
            end
        end
    end

    assign PC_out      = r_pc;
    assign inc_PC      = w_inc;
    assign pred_taken  = w_hit;
    assign pred_target = w_pred_target;

endmodule
